// File: rtl/lcd_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_write_ctrl                                                 |
// | Purpose  : Responder end of the LCD character-write handshake. After      |
// |            reset it runs the HD44780 8-bit power-up initialisation,       |
// |            raises initDone, then writes one ASCII byte per accepted       |
// |            writeStart with full setup / E-pulse / hold / execution timing |
// |            and answers with a one-cycle writeDone.                        |
// | Ports    : clkFSM     - system clock                                      |
// |            resetFSM   - synchronous active-high reset                     |
// |            writeStart - request pulse, sampled only in READY              |
// |            data[7:0]  - character, sampled with the accepted writeStart   |
// |            initDone   - LCD initialised (held until reset)                |
// |            writeDone  - one-cycle pulse when a write has completed        |
// |            LCD_E/LCD_RS/LCD_RW/LCD_DB[7:0] - LCD bus (RW tied low)        |
// | Options  : `define LCD_LINE_WRAP_EN to issue a set-DDRAM-address command  |
// |            (line 2 / line 1, alternating) whenever the column wraps.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module lcd_write_ctrl #(
  parameter int PWRUP_CYC      = 750000,
  parameter int INIT_WAIT_CYC  = 250000,
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clkFSM,
  input  logic       resetFSM,
  input  logic       writeStart,
  input  logic [7:0] data,
  output logic       initDone,
  output logic       writeDone,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DB
);

  // Counter must hold the largest wait minus one.
  localparam int c_MAX_A   = (PWRUP_CYC > INIT_WAIT_CYC) ? PWRUP_CYC : INIT_WAIT_CYC;
  localparam int c_MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int c_MAX_C   = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
  localparam int c_MAX_AB  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAX_CYC = (c_MAX_AB > c_MAX_C) ? c_MAX_AB : c_MAX_C;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  localparam logic [2:0] c_PWRUP = 3'd0;
  localparam logic [2:0] c_SETUP = 3'd1;
  localparam logic [2:0] c_EHIGH = 3'd2;
  localparam logic [2:0] c_HOLD  = 3'd3;
  localparam logic [2:0] c_EXEC  = 3'd4;
  localparam logic [2:0] c_READY = 3'd5;
  localparam logic [2:0] c_DONE  = 3'd6;

  // What the transaction currently on the bus is, so EXEC knows where to go.
  localparam logic [1:0] c_KIND_INIT   = 2'd0;
  localparam logic [1:0] c_KIND_DATA   = 2'd1;
`ifdef LCD_LINE_WRAP_EN
  localparam logic [1:0] c_KIND_CURSOR = 2'd2;
`endif

  localparam logic [2:0] c_LAST_INIT = 3'd6;

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_initIdx;
  logic [3:0]         r_col;
  logic [7:0]         r_db;
  logic               r_rs;
  logic               r_initDone;
  logic [1:0]         r_kind;
`ifdef LCD_LINE_WRAP_EN
  logic               r_line;     // 0 = cursor on line 1, 1 = line 2
  logic               w_colWrap;
`endif

  logic [7:0]         w_initCmd;
  logic [7:0]         w_nextInitCmd;
  logic [c_CNT_W-1:0] w_execLoad;

  function automatic logic [7:0] initCmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: initCmd = 8'h30;  // function set, 8-bit (x3)
      3'd3:             initCmd = 8'h38;  // 8-bit, 2 lines, 5x8 font
      3'd4:             initCmd = 8'h0C;  // display on, cursor off
      3'd5:             initCmd = 8'h06;  // entry mode: increment
      default:          initCmd = 8'h01;  // clear display
    endcase
  endfunction

  assign w_initCmd     = initCmd(r_initIdx);
  assign w_nextInitCmd = initCmd(r_initIdx + 3'd1);
`ifdef LCD_LINE_WRAP_EN
  assign w_colWrap     = (r_col == 4'd15);
`endif

  // Execution wait (minus one) for the command currently on the bus.
  always_comb begin
    w_execLoad = c_CNT_W'(CMD_WAIT_CYC - 1);
    if (r_kind == c_KIND_INIT) begin
      if (r_initIdx < 3'd3) begin
        w_execLoad = c_CNT_W'(INIT_WAIT_CYC - 1);
      end else if (r_initIdx == c_LAST_INIT) begin
        w_execLoad = c_CNT_W'(CLEAR_WAIT_CYC - 1);
      end
    end
  end

  // Waits load N-1 on entry and leave when the counter reaches zero, so a
  // wait of N occupies exactly N cycles. Power-up instead counts up from the
  // reset value of zero to PWRUP_CYC-1, which keeps the reset value at zero.
  always_ff @(posedge clkFSM) begin
    if (resetFSM) begin
      r_state    <= c_PWRUP;
      r_cnt      <= '0;
      r_initIdx  <= '0;
      r_col      <= '0;
      r_db       <= 8'h00;
      r_rs       <= 1'b0;
      r_initDone <= 1'b0;
      r_kind     <= c_KIND_INIT;
`ifdef LCD_LINE_WRAP_EN
      r_line     <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_PWRUP: begin
          if (r_cnt == c_CNT_W'(PWRUP_CYC - 1)) begin
            r_state <= c_SETUP;
            r_cnt   <= c_CNT_W'(SETUP_CYC - 1);
            r_db    <= w_initCmd;
            r_rs    <= 1'b0;
            r_kind  <= c_KIND_INIT;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= c_EHIGH;
            r_cnt   <= c_CNT_W'(E_PULSE_CYC - 1);
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        c_EHIGH: begin
          if (r_cnt == '0) begin
            r_state <= c_HOLD;
            r_cnt   <= c_CNT_W'(SETUP_CYC - 1);
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        c_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= c_EXEC;
            r_cnt   <= w_execLoad;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        c_EXEC: begin
          if (r_cnt == '0) begin
            case (r_kind)
              c_KIND_INIT: begin
                if (r_initIdx == c_LAST_INIT) begin
                  r_state    <= c_READY;
                  r_initDone <= 1'b1;
                end else begin
                  r_initIdx <= r_initIdx + 3'd1;
                  r_db      <= w_nextInitCmd;
                  r_state   <= c_SETUP;
                  r_cnt     <= c_CNT_W'(SETUP_CYC - 1);
                end
              end
              c_KIND_DATA: begin
                r_col <= r_col + 4'd1;
`ifdef LCD_LINE_WRAP_EN
                if (w_colWrap) begin
                  // Move the cursor to the start of the other line before
                  // reporting the write as done.
                  r_db    <= r_line ? 8'h80 : 8'hC0;
                  r_line  <= ~r_line;
                  r_rs    <= 1'b0;
                  r_kind  <= c_KIND_CURSOR;
                  r_state <= c_SETUP;
                  r_cnt   <= c_CNT_W'(SETUP_CYC - 1);
                end else begin
                  r_state <= c_DONE;
                end
`else
                r_state <= c_DONE;
`endif
              end
              default: begin
                r_state <= c_DONE;
              end
            endcase
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        c_READY: begin
          if (writeStart) begin
            r_db    <= data;
            r_rs    <= 1'b1;
            r_kind  <= c_KIND_DATA;
            r_state <= c_SETUP;
            r_cnt   <= c_CNT_W'(SETUP_CYC - 1);
          end
        end
        c_DONE: begin
          r_state <= c_READY;
        end
        default: begin
          r_state <= c_PWRUP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign initDone  = r_initDone;
  assign writeDone = (r_state == c_DONE);
  assign LCD_E     = (r_state == c_EHIGH);
  assign LCD_RS    = r_rs;
  assign LCD_RW    = 1'b0;
  assign LCD_DB    = r_db;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lcd_write_ctrl                                              |
// | Purpose  : Directed self-checking bench for lcd_write_ctrl using short    |
// |            timing parameters. Honours LCD_LINE_WRAP_EN like the design.  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_lcd_write_ctrl;

  localparam int P_PWRUP = 20;
  localparam int P_INIT  = 10;
  localparam int P_SETUP = 2;
  localparam int P_EPUL  = 3;
  localparam int P_CMD   = 5;
  localparam int P_CLEAR = 8;

  // Hand-computed: cycle index (0 = first cycle after reset release) at
  // which each init E pulse rises, and the cycle READY is entered.
  localparam int         EXP_CYC [7] = '{22, 39, 56, 73, 85, 97, 109};
  localparam logic [7:0] EXP_DB  [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h06, 8'h01};
  localparam int         EXP_READY   = 122;

  logic       clk = 1'b0;
  logic       resetFSM = 1'b1;
  logic       writeStart = 1'b0;
  logic [7:0] data = 8'h00;
  logic       initDone, writeDone, lcdE, lcdRs, lcdRw;
  logic [7:0] lcdDb;

  lcd_write_ctrl #(
    .PWRUP_CYC(P_PWRUP), .INIT_WAIT_CYC(P_INIT), .SETUP_CYC(P_SETUP),
    .E_PULSE_CYC(P_EPUL), .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLEAR)
  ) dut (
    .clkFSM(clk), .resetFSM(resetFSM), .writeStart(writeStart), .data(data),
    .initDone(initDone), .writeDone(writeDone), .LCD_E(lcdE), .LCD_RS(lcdRs),
    .LCD_RW(lcdRw), .LCD_DB(lcdDb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rstCount = 0;
  int wdCount = 0;

  always @(posedge clk) begin
    if (resetFSM) begin
      cyc      <= 0;
      rstCount <= rstCount + 1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] db;
  } pulse_t;
  pulse_t pulses[$];

  // Bus monitor: logs each E pulse and checks width and RS/DB stability
  // through E high and the hold window after E falls.
  initial begin
    int     seenRst = 0;
    logic   prevE = 1'b0;
    bit     inPulse = 0;
    int     eWidth = 0;
    int     holdLeft = 0;
    logic   latRs;
    logic [7:0] latDb;
    pulse_t p;
    forever begin
      @(negedge clk);
      if (rstCount != seenRst) begin
        seenRst  = rstCount;
        inPulse  = 0;
        holdLeft = 0;
      end else if (lcdE === 1'b1 && prevE !== 1'b1) begin
        p.cyc = cyc; p.rs = lcdRs; p.db = lcdDb;
        pulses.push_back(p);
        inPulse = 1; eWidth = 1; latRs = lcdRs; latDb = lcdDb;
      end else if (lcdE === 1'b1) begin
        eWidth++;
        checks++;
        if ({lcdRs, lcdDb} !== {latRs, latDb}) begin
          failures++;
          $display("FAIL bus_stable_e: rs/db=%b/%h want %b/%h at cyc %0d", lcdRs, lcdDb, latRs, latDb, cyc);
        end
      end else if (prevE === 1'b1 && inPulse) begin
        inPulse = 0;
        checks++;
        if (eWidth != P_EPUL) begin
          failures++;
          $display("FAIL e_width: got %0d want %0d at cyc %0d", eWidth, P_EPUL, cyc);
        end
        checks++;
        if ({lcdRs, lcdDb} !== {latRs, latDb}) begin
          failures++;
          $display("FAIL bus_stable_hold: rs/db=%b/%h want %b/%h at cyc %0d", lcdRs, lcdDb, latRs, latDb, cyc);
        end
        holdLeft = P_SETUP - 1;
      end else if (holdLeft > 0) begin
        holdLeft--;
        checks++;
        if ({lcdRs, lcdDb} !== {latRs, latDb}) begin
          failures++;
          $display("FAIL bus_stable_hold: rs/db=%b/%h want %b/%h at cyc %0d", lcdRs, lcdDb, latRs, latDb, cyc);
        end
      end
      if (writeDone === 1'b1) wdCount++;
      prevE = lcdE;
    end
  end

  // Called at a negedge while READY; returns at the negedge of the
  // writeDone cycle. lat = -1 if writeDone never came.
  task automatic doWrite(input logic [7:0] d, output int tAcc, output int lat, output bit initLow);
    initLow = 0;
    lat     = -1;
    tAcc    = cyc;
    writeStart = 1'b1;
    data       = d;
    @(negedge clk);
    writeStart = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (initDone !== 1'b1) initLow = 1;
      if (writeDone === 1'b1) begin
        lat = cyc - tAcc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Expects reset to have just been released (cyc == 0).
  task automatic test_init();
    int readyCyc = -1;
    int wd0;
    pulses.delete();
    wd0 = wdCount;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cyc == 50) begin writeStart = 1'b1; data = 8'h55; end
      if (cyc == 51) begin writeStart = 1'b0; data = 8'h00; end
      if (initDone === 1'b1) begin
        readyCyc = cyc;
        break;
      end
    end
    writeStart = 1'b0;
    checks++;
    if (readyCyc != EXP_READY) begin
      failures++;
      $display("FAIL init_done_cycle: got %0d want %0d", readyCyc, EXP_READY);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pulses.size() != 7) begin
      failures++;
      $display("FAIL init_pulse_count: got %0d want 7", pulses.size());
    end
    for (int k = 0; k < 7; k++) begin
      if (k < pulses.size()) begin
        checks++;
        if (pulses[k].db !== EXP_DB[k] || pulses[k].rs !== 1'b0 || pulses[k].cyc != EXP_CYC[k]) begin
          failures++;
          $display("FAIL init_cmd%0d: db=%h rs=%b cyc=%0d want db=%h rs=0 cyc=%0d",
                   k, pulses[k].db, pulses[k].rs, pulses[k].cyc, EXP_DB[k], EXP_CYC[k]);
        end
      end
    end
    checks++;
    if (wdCount != wd0) begin
      failures++;
      $display("FAIL init_no_writedone: got %0d pulses want 0", wdCount - wd0);
    end
  endtask

  task automatic test_reset();
    resetFSM = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({initDone, writeDone, lcdE, lcdRs, lcdRw} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: initDone/writeDone/E/RS/RW=%b want 00000", {initDone, writeDone, lcdE, lcdRs, lcdRw});
    end
    checks++;
    if (lcdDb !== 8'h00) begin
      failures++;
      $display("FAIL reset_db: got %h want 00", lcdDb);
    end
    resetFSM = 1'b0;
    test_init();
  endtask

  task automatic test_single_write();
    int t, lat, wd0;
    bit initLow;
    pulses.delete();
    wd0 = wdCount;
    doWrite(8'h31, t, lat, initLow);
    checks++;
    if (lat != 13) begin
      failures++;
      $display("FAIL single_latency: got %0d want 13", lat);
    end
    @(negedge clk);
    checks++;
    if (writeDone !== 1'b0) begin
      failures++;
      $display("FAIL single_done_width: writeDone=%b want 0 one cycle later", writeDone);
    end
    checks++;
    if (initLow || initDone !== 1'b1 || lcdRw !== 1'b0) begin
      failures++;
      $display("FAIL single_initdone_rw: initLow=%0d initDone=%b rw=%b want 0/1/0", initLow, initDone, lcdRw);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pulses.size() != 1 || pulses[0].rs !== 1'b1 || pulses[0].db !== 8'h31 || pulses[0].cyc != t + 3) begin
      failures++;
      $display("FAIL single_pulse: count=%0d rs=%b db=%h cyc=%0d want 1/1/31/%0d",
               pulses.size(), (pulses.size() > 0) ? pulses[0].rs : 1'bx,
               (pulses.size() > 0) ? pulses[0].db : 8'hxx, (pulses.size() > 0) ? pulses[0].cyc : -1, t + 3);
    end
    checks++;
    if (wdCount - wd0 != 1) begin
      failures++;
      $display("FAIL single_wd_count: got %0d want 1", wdCount - wd0);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, lat1, lat2, wd0;
    bit l1, l2;
    pulses.delete();
    wd0 = wdCount;
    doWrite(8'h31, t1, lat1, l1);
    @(negedge clk);
    doWrite(8'h38, t2, lat2, l2);
    checks++;
    if (lat1 != 13 || lat2 != 13 || t2 != t1 + 14) begin
      failures++;
      $display("FAIL b2b_timing: lat1=%0d lat2=%0d gap=%0d want 13/13/14", lat1, lat2, t2 - t1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (pulses.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulse_count: got %0d want 2", pulses.size());
    end else begin
      checks++;
      if (pulses[0].db !== 8'h31 || pulses[1].db !== 8'h38 || pulses[0].rs !== 1'b1 ||
          pulses[1].rs !== 1'b1 || pulses[1].cyc != t2 + 3) begin
        failures++;
        $display("FAIL b2b_order: db=%h,%h rs=%b,%b cyc2=%0d want 31,38 1,1 %0d",
                 pulses[0].db, pulses[1].db, pulses[0].rs, pulses[1].rs, pulses[1].cyc, t2 + 3);
      end
    end
    checks++;
    if (wdCount - wd0 != 2) begin
      failures++;
      $display("FAIL b2b_wd_count: got %0d want 2", wdCount - wd0);
    end
  endtask

  task automatic test_ignore_midwrite();
    int t, lat, wd0;
    pulses.delete();
    wd0 = wdCount;
    lat = -1;
    t = cyc;
    writeStart = 1'b1; data = 8'h41;
    @(negedge clk);
    writeStart = 1'b0;
    repeat (3) @(negedge clk);            // cyc t+4: E high
    writeStart = 1'b1; data = 8'hAA;
    @(negedge clk);
    writeStart = 1'b0;
    repeat (4) @(negedge clk);            // cyc t+9: execution wait
    writeStart = 1'b1; data = 8'h55;
    @(negedge clk);
    writeStart = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (writeDone === 1'b1) begin
        lat = cyc - t;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != 13) begin
      failures++;
      $display("FAIL ignore_latency: got %0d want 13", lat);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (pulses.size() != 1 || pulses[0].db !== 8'h41 || pulses[0].cyc != t + 3) begin
      failures++;
      $display("FAIL ignore_pulses: count=%0d db0=%h want 1 pulse db 41",
               pulses.size(), (pulses.size() > 0) ? pulses[0].db : 8'hxx);
    end
    checks++;
    if (wdCount - wd0 != 1) begin
      failures++;
      $display("FAIL ignore_wd_count: got %0d want 1", wdCount - wd0);
    end
  endtask

  task automatic test_reset_midwrite();
    int t;
    t = cyc;
    writeStart = 1'b1; data = 8'h42;
    @(negedge clk);
    writeStart = 1'b0;
    repeat (3) @(negedge clk);            // cyc t+4: E high
    checks++;
    if (lcdE !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_e_high: E=%b want 1 before reset", lcdE);
    end
    resetFSM = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({lcdE, initDone, writeDone, lcdRs} !== 4'b0 || lcdDb !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs: E/initDone/writeDone/RS=%b DB=%h want 0000 00",
               {lcdE, initDone, writeDone, lcdRs}, lcdDb);
    end
    resetFSM = 1'b0;
    test_init();
  endtask

  task automatic checkWrapBatch(input int expData, input logic [7:0] expCursor, input int tLast);
    int dataCnt = 0;
    int bad = 0;
    int curCnt = 0;
    logic [7:0] expD;
    foreach (pulses[k]) begin
      if (pulses[k].rs === 1'b1) begin
        expD = 8'h41 + 8'(dataCnt);
        if (pulses[k].db !== expD) bad++;
        dataCnt++;
      end else begin
        curCnt++;
      end
    end
    checks++;
    if (dataCnt != expData || bad != 0) begin
      failures++;
      $display("FAIL wrap_data: count=%0d bad=%0d want %0d/0", dataCnt, bad, expData);
    end
`ifdef LCD_LINE_WRAP_EN
    checks++;
    if (curCnt != expData / 16 || pulses[pulses.size() - 1].rs !== 1'b0 ||
        pulses[pulses.size() - 1].db !== expCursor || pulses[pulses.size() - 1].cyc != tLast + 15) begin
      failures++;
      $display("FAIL wrap_cursor: count=%0d db=%h cyc=%0d want %0d/%h/%0d", curCnt,
               pulses[pulses.size() - 1].db, pulses[pulses.size() - 1].cyc, expData / 16, expCursor, tLast + 15);
    end
`else
    checks++;
    if (curCnt != 0) begin
      failures++;
      $display("FAIL wrap_no_cursor: got %0d RS=0 pulses want 0 (cursor %h unexpected)", curCnt, expCursor);
    end
`endif
  endtask

  task automatic test_line_wrap();
    int t, lat, expLat;
    bit initLow;
    pulses.delete();
    for (int i = 0; i < 32; i++) begin
      doWrite(8'h41 + 8'(i), t, lat, initLow);
      expLat = 13;
`ifdef LCD_LINE_WRAP_EN
      if (i == 15 || i == 31) expLat = 25;
`endif
      checks++;
      if (lat != expLat) begin
        failures++;
        $display("FAIL wrap_latency%0d: got %0d want %0d", i, lat, expLat);
      end
      @(negedge clk);
      if (i == 15) begin
        repeat (5) @(negedge clk);
        checkWrapBatch(16, 8'hC0, t);
      end
    end
    repeat (5) @(negedge clk);
    checkWrapBatch(32, 8'h80, t);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_ignore_midwrite();
    test_reset_midwrite();
    test_line_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
